// File: rtl/npu_stall_ctrl.sv
// Freezes the pipeline around a CPU store to the NPU command register,
// launches the NPU, waits for done or timeout, and counts stall cycles.
module npu_stall_ctrl #(
   parameter logic [31:0] NPU_CMD_ADDR = 32'h1000_0000,
   parameter int          TIMEOUT      = 4096,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ex_mem_valid,
   input  logic             ex_mem_memwrite,
   input  logic [31:0]      ex_mem_addr,
   input  logic [31:0]      ex_mem_wdata,
   input  logic             flush,
   input  logic             npu_busy,
   input  logic             npu_done,
   input  logic             perf_clr,
   output logic             npu_stall,
   output logic             npu_start,
   output logic [31:0]      npu_cmd,
   output logic             npu_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             trigger;

   assign trigger = ex_mem_valid & ex_mem_memwrite &
                    (ex_mem_addr == NPU_CMD_ADDR) & ~flush;

   // The trigger only matters in IDLE, so DONE never re-detects the store.
   always_comb begin
      npu_stall = 1'b0;
      npu_start = 1'b0;
      if (reset_n) begin
         case (state)
            S_IDLE:   npu_stall = trigger;
            S_LAUNCH: begin
               npu_stall = 1'b1;
               npu_start = ~npu_busy;
            end
            S_WAIT:   npu_stall = 1'b1;
            default:  npu_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         npu_cmd      <= '0;
         npu_timeout  <= 1'b0;
         stall_cycles <= '0;
         tmo_cnt      <= '0;
      end else begin
         if (perf_clr)
            stall_cycles <= '0;
         else if (npu_stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;

         unique case (state)
            S_IDLE: begin
               if (trigger) begin
                  npu_cmd <= ex_mem_wdata;
                  state   <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (!npu_busy) begin
                  tmo_cnt <= '0;
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (npu_done) begin
                  state <= S_DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  npu_timeout <= 1'b1;
                  state       <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_npu_stall_ctrl.sv
// Randomized bench for npu_stall_ctrl against a transaction-level model,
// with directed launch, timeout-boundary and reset scenarios first.
module tb_npu_stall_ctrl;

   localparam logic [31:0] CMD  = 32'h1000_0000;
   localparam int          TMO  = 8;
   localparam int          CW   = 6;
   localparam int          SMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ex_mem_valid;
   logic          ex_mem_memwrite;
   logic [31:0]   ex_mem_addr;
   logic [31:0]   ex_mem_wdata;
   logic          flush;
   logic          npu_busy;
   logic          npu_done;
   logic          perf_clr;
   logic          npu_stall;
   logic          npu_start;
   logic [31:0]   npu_cmd;
   logic          npu_timeout;
   logic [CW-1:0] stall_cycles;
   logic [1:0]    state_o;

   int checks = 0;
   int failures = 0;

   npu_stall_ctrl #(
      .NPU_CMD_ADDR(CMD),
      .TIMEOUT(TMO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .ex_mem_valid(ex_mem_valid),
      .ex_mem_memwrite(ex_mem_memwrite),
      .ex_mem_addr(ex_mem_addr),
      .ex_mem_wdata(ex_mem_wdata),
      .flush(flush),
      .npu_busy(npu_busy),
      .npu_done(npu_done),
      .perf_clr(perf_clr),
      .npu_stall(npu_stall),
      .npu_start(npu_start),
      .npu_cmd(npu_cmd),
      .npu_timeout(npu_timeout),
      .stall_cycles(stall_cycles),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Model: a command is "in flight" from acceptance until retire.
   // Phases: waiting for the NPU to accept, then counting wait age.
   bit          m_inflight;
   bit          m_accepted;
   int          m_age;
   bit          m_retire;
   logic [31:0] m_cmd;
   bit          m_to;
   int          m_stalls;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_state();
      if (m_retire) return 3;
      if (!m_inflight) return 0;
      return m_accepted ? 2 : 1;
   endfunction

   task automatic step(input bit rn, input bit v, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit fl, input bit bz, input bit dn,
                       input bit pc);
      bit trig, e_stall, e_start;
      reset_n = rn; ex_mem_valid = v; ex_mem_memwrite = w;
      ex_mem_addr = a; ex_mem_wdata = d; flush = fl;
      npu_busy = bz; npu_done = dn; perf_clr = pc;
      trig = v && w && (a == CMD) && !fl;
      e_stall = rn && ((m_state() == 0 && trig) || m_inflight);
      e_start = rn && m_inflight && !m_accepted && !bz;
      @(negedge clk);
      chk("stall", {31'd0, npu_stall}, {31'd0, e_stall});
      chk("start", {31'd0, npu_start}, {31'd0, e_start});
      chk("state", {30'd0, state_o}, m_state());
      chk("cmd", npu_cmd, m_cmd);
      chk("timeout", {31'd0, npu_timeout}, {31'd0, m_to});
      chk("stall_cycles", {26'd0, stall_cycles}, m_stalls);
      @(posedge clk);
      if (!rn) begin
         m_inflight = 0; m_accepted = 0; m_age = 0;
         m_retire = 0; m_cmd = '0; m_to = 0; m_stalls = 0;
      end else begin
         if (pc) m_stalls = 0;
         else if (e_stall && m_stalls < SMAX) m_stalls++;
         if (m_retire) begin
            m_retire = 0;
         end else if (!m_inflight) begin
            if (trig) begin
               m_inflight = 1; m_accepted = 0; m_cmd = d;
            end
         end else if (!m_accepted) begin
            if (!bz) begin
               m_accepted = 1; m_age = 0;
            end
         end else begin
            m_age++;
            if (dn || m_age == TMO) begin
               if (!dn) m_to = 1;
               m_inflight = 0; m_retire = 1;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
   endtask

   task automatic store(input int n, input bit bz, input bit dn);
      for (int i = 0; i < n; i++)
         step(1, 1, 1, CMD, 32'hA5A5_0001, 0, bz, dn, 0);
   endtask

   initial begin
      reset_n = 0; ex_mem_valid = 0; ex_mem_memwrite = 0;
      ex_mem_addr = '0; ex_mem_wdata = '0; flush = 0;
      npu_busy = 0; npu_done = 0; perf_clr = 0;
      m_inflight = 0; m_accepted = 0; m_age = 0; m_retire = 0;
      m_cmd = '0; m_to = 0; m_stalls = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", {30'd0, state_o}, 32'd0);
      chk("rst_stall_cycles", {26'd0, stall_cycles}, 32'd0);

      // basic launch: T trigger, T+1 start, done at T+6, DONE at T+7
      store(6, 0, 0);
      store(1, 0, 1);
      chk("basic_state_done", {30'd0, state_o}, 32'd3);
      store(1, 0, 0);
      chk("basic_no_retrigger", {30'd0, state_o}, 32'd0);
      chk("basic_cmd", npu_cmd, 32'hA5A5_0001);
      chk("basic_stalls", {26'd0, stall_cycles}, 32'd7);
      idle(2);

      // busy hold then done on the last allowed wait cycle
      store(1, 0, 0);
      store(3, 1, 0);
      store(1, 0, 0);
      store(TMO - 1, 0, 0);
      store(1, 0, 1);
      chk("edge_timeout", {31'd0, npu_timeout}, 32'd0);
      idle(2);

      // flush and non-matching accesses
      step(1, 1, 1, CMD, 32'h1, 1, 0, 0, 0);
      step(1, 1, 1, CMD + 4, 32'h2, 0, 0, 0, 0);
      step(1, 1, 0, CMD, 32'h3, 0, 0, 0, 0);
      chk("nomatch_state", {30'd0, state_o}, 32'd0);

      // timeout, perf_clr during stall
      store(2, 0, 0);
      store(1, 0, 0);
      step(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 1);
      store(TMO - 2, 0, 0);
      chk("to_state", {30'd0, state_o}, 32'd3);
      chk("to_flag", {31'd0, npu_timeout}, 32'd1);
      idle(3);
      chk("to_sticky", {31'd0, npu_timeout}, 32'd1);

      // reset in the middle of WAIT, then a late done
      store(4, 0, 0);
      step(0, 1, 1, CMD, 32'h5, 0, 0, 0, 0);
      step(1, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
      chk("rst_mid_to", {31'd0, npu_timeout}, 32'd0);
      chk("rst_mid_state", {30'd0, state_o}, 32'd0);

      for (int i = 0; i < 4000; i++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         a = (sel < 6) ? CMD : (sel < 8) ? CMD + 4 : $urandom;
         step($urandom_range(0, 199) != 0,
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0,
              a, $urandom,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 11) == 0,
              $urandom_range(0, 63) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
